// File: rtl/tvip_axi_slave_ram_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tvip_axi_slave_ram_if : AXI4 AW/W/B/AR/R bundle with master and slave views
// Revision 1.0
// ---------------------------------------------------------------------------
interface tvip_axi_slave_ram_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [2:0]              awprot;
  logic [3:0]              awqos;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;

  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [2:0]              arprot;
  logic [3:0]              arqos;

  logic                    rvalid;
  logic                    rready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, awprot, awqos,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, arprot, arqos,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awprot, awqos,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, arprot, arqos,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );
endinterface
`default_nettype wire

// File: rtl/tvip_axi_slave_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tvip_axi_slave_ram : AXI4 slave backed by a word RAM, one outstanding txn per direction
// Revision 1.0
// ---------------------------------------------------------------------------
module tvip_axi_slave_ram #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input wire                  aclk,
  input wire                  areset_n,
  tvip_axi_slave_ram_if.slave axi
);
  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int LANE_LG = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;

  function automatic logic f_illegal(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == 2'd2) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (burst == 2'd3) || (int'(size) > LANE_LG) || bad_wrap;
  endfunction

  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> LANE_LG) < ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] f_index(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> LANE_LG);
  endfunction

  // WRAP boundary is a power of two for every legal length, so a mask suffices.
  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, incr, wmask;
    step  = ADDR_WIDTH'(1) << size;
    incr  = (addr & ~(step - ADDR_WIDTH'(1))) + step;
    wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'd0:    return addr;
      2'd2:    return (addr & ~wmask) | (incr & wmask);
      default: return incr;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // ---------------- write path ----------------
  wr_state_e             wr_state_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q, wr_id_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [7:0]            wr_len_q;
  logic [2:0]            wr_size_q;
  logic [1:0]            wr_burst_q;
  logic                  wr_illegal_q, wr_err_q;
  logic [8:0]            wr_cnt_q;
  logic                  w_wr_beat_ok, w_mem_we;

  assign w_wr_beat_ok = !wr_illegal_q && f_in_range(wr_addr_q) && (wr_cnt_q <= {1'b0, wr_len_q});
  assign w_mem_we     = (wr_state_q == W_DATA) && wready_q && axi.wvalid && w_wr_beat_ok;

  always_ff @(posedge aclk) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.wstrb[b]) mem_q[f_index(wr_addr_q)][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_state_q   <= W_IDLE;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bid_q        <= '0;
      bresp_q      <= RESP_OKAY;
      wr_id_q      <= '0;
      wr_addr_q    <= '0;
      wr_len_q     <= '0;
      wr_size_q    <= '0;
      wr_burst_q   <= '0;
      wr_illegal_q <= 1'b0;
      wr_err_q     <= 1'b0;
      wr_cnt_q     <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (awready_q && axi.awvalid) begin
            wr_id_q      <= axi.awid;
            wr_addr_q    <= axi.awaddr;
            wr_len_q     <= axi.awlen;
            wr_size_q    <= axi.awsize;
            wr_burst_q   <= axi.awburst;
            wr_illegal_q <= f_illegal(axi.awlen, axi.awsize, axi.awburst);
            wr_err_q     <= 1'b0;
            wr_cnt_q     <= '0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b1;
            wr_state_q   <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (wready_q && axi.wvalid) begin
            wr_addr_q <= f_next_addr(wr_addr_q, wr_len_q, wr_size_q, wr_burst_q);
            if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 9'd1;
            if (!w_wr_beat_ok) wr_err_q <= 1'b1;
            if (axi.wlast) begin
              wready_q   <= 1'b0;
              bvalid_q   <= 1'b1;
              bid_q      <= wr_id_q;
              bresp_q    <= (wr_err_q || !w_wr_beat_ok || wr_cnt_q != {1'b0, wr_len_q})
                            ? RESP_SLVERR : RESP_OKAY;
              wr_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi.bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  rd_state_e             rd_state_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [7:0]            rd_len_q, rd_beat_q;
  logic [2:0]            rd_size_q;
  logic [1:0]            rd_burst_q;
  logic                  rd_illegal_q;
  logic [ADDR_WIDTH-1:0] w_rd_next, w_rd_addr;
  logic                  w_rd_illegal, w_rd_err;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // The beat being loaded is beat 0 of a new request in IDLE, otherwise the successor.
  assign w_rd_next    = f_next_addr(rd_addr_q, rd_len_q, rd_size_q, rd_burst_q);
  assign w_rd_addr    = (rd_state_q == R_IDLE) ? axi.araddr : w_rd_next;
  assign w_rd_illegal = (rd_state_q == R_IDLE) ? f_illegal(axi.arlen, axi.arsize, axi.arburst)
                                               : rd_illegal_q;
  assign w_rd_err     = w_rd_illegal || !f_in_range(w_rd_addr);
  assign w_rd_word    = w_rd_err ? '0 : mem_q[f_index(w_rd_addr)];

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rd_state_q   <= R_IDLE;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      rid_q        <= '0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      rd_addr_q    <= '0;
      rd_len_q     <= '0;
      rd_beat_q    <= '0;
      rd_size_q    <= '0;
      rd_burst_q   <= '0;
      rd_illegal_q <= 1'b0;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (arready_q && axi.arvalid) begin
            rid_q        <= axi.arid;
            rd_addr_q    <= axi.araddr;
            rd_len_q     <= axi.arlen;
            rd_size_q    <= axi.arsize;
            rd_burst_q   <= axi.arburst;
            rd_illegal_q <= w_rd_illegal;
            rd_beat_q    <= '0;
            rdata_q      <= w_rd_word;
            rresp_q      <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
            rlast_q      <= (axi.arlen == 8'd0);
            rvalid_q     <= 1'b1;
            arready_q    <= 1'b0;
            rd_state_q   <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (rvalid_q && axi.rready) begin
            if (rlast_q) begin
              rvalid_q   <= 1'b0;
              rlast_q    <= 1'b0;
              arready_q  <= 1'b1;
              rd_state_q <= R_IDLE;
            end else begin
              rd_addr_q <= w_rd_next;
              rd_beat_q <= rd_beat_q + 8'd1;
              rdata_q   <= w_rd_word;
              rresp_q   <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
              rlast_q   <= (rd_beat_q + 8'd1 == rd_len_q);
            end
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rid     = rid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;

  logic w_unused;
  assign w_unused = ^{axi.awprot, axi.awqos, axi.arprot, axi.arqos};
endmodule
`default_nettype wire

// File: tb/tb_tvip_axi_slave_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tvip_axi_slave_ram : random AXI traffic scored against a byte-level memory model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_tvip_axi_slave_ram;
  localparam int IDW = 4, AW = 32, DW = 32, DEPTH = 256, NB = DW / 8, LB = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tvip_axi_slave_ram_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();
  tvip_axi_slave_ram #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH))
    dut (.aclk(clk), .areset_n(rst_n), .axi(axi));

  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      b_q[$];
  r_exp_t      r_q[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] wd_a [512];
  logic [3:0]  ws_a [512];
  int          n_checks = 0, n_pass = 0;
  logic        hold_b = 1'b0, hold_r = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got no event within bound, required one", name);
  endtask

  function automatic bit legal(input int len, input int size, input int burst);
    if (burst == 3 || size > LB) return 1'b0;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
    return 1'b1;
  endfunction

  // Address of beat k from the burst rules: aligned stepping, wrapping inside a len+1 window.
  function automatic int beat_addr(input int addr, input int len, input int size,
                                   input int burst, input int k);
    int step, aligned, total, base;
    step    = 1 << size;
    aligned = (addr / step) * step;
    total   = (len + 1) * step;
    base    = (addr / total) * total;
    if (k == 0 || burst == 0) return addr;
    if (burst == 2) return base + ((aligned + k * step) % total);
    return aligned + k * step;
  endfunction

  function automatic bit in_range(input int a);
    return (a / NB) < DEPTH;
  endfunction

  task automatic do_write(input logic [3:0] id, input int addr, input int len, input int size,
                          input int burst, input int nbeats);
    bit err;
    int a, t;
    err = !legal(len, size, burst);
    for (int k = 0; k < nbeats; k++) begin
      a = beat_addr(addr, len, size, burst, k);
      if (legal(len, size, burst) && in_range(a) && k <= len) begin
        for (int b = 0; b < NB; b++)
          if (ws_a[k][b]) mem_m[a / NB][b*8 +: 8] = wd_a[k][b*8 +: 8];
      end else begin
        err = 1'b1;
      end
    end
    if (nbeats != len + 1) err = 1'b1;
    b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    axi.awid = id; axi.awaddr = 32'(addr); axi.awlen = 8'(len);
    axi.awsize = 3'(size); axi.awburst = 2'(burst); axi.awvalid = 1'b1;
    t = 0;
    while (axi.awready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail_now("aw_handshake");
    @(negedge clk);
    axi.awvalid = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      if ($urandom_range(0, 3) == 0) begin axi.wvalid = 1'b0; @(negedge clk); end
      axi.wdata = wd_a[k]; axi.wstrb = ws_a[k]; axi.wlast = (k == nbeats - 1); axi.wvalid = 1'b1;
      t = 0;
      while (axi.wready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) fail_now("w_handshake");
      @(negedge clk);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input int addr, input int len, input int size,
                         input int burst);
    int a, t;
    for (int k = 0; k <= len; k++) begin
      a = beat_addr(addr, len, size, burst, k);
      if (legal(len, size, burst) && in_range(a))
        r_q.push_back('{id: id, data: mem_m[a / NB], resp: 2'b00, last: (k == len)});
      else
        r_q.push_back('{id: id, data: 32'h0, resp: 2'b10, last: (k == len)});
    end
    axi.arid = id; axi.araddr = 32'(addr); axi.arlen = 8'(len);
    axi.arsize = 3'(size); axi.arburst = 2'(burst); axi.arvalid = 1'b1;
    t = 0;
    while (axi.arready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail_now("ar_handshake");
    @(negedge clk);
    axi.arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) fail_now("drain");
  endtask

  // Monitor: chooses ready for the coming edge, then scores any handshake it will complete.
  initial begin
    bit     b_stall, r_stall;
    b_exp_t bprev, be;
    r_exp_t rprev, re;
    b_stall = 1'b0; r_stall = 1'b0; bprev = '0; rprev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b_stall = 1'b0; r_stall = 1'b0; axi.bready = 1'b0; axi.rready = 1'b0;
        continue;
      end
      axi.bready = !hold_b && ($urandom_range(0, 3) != 0);
      axi.rready = !hold_r && ($urandom_range(0, 3) != 0);
      if (b_stall)
        chk("b_hold", {axi.bvalid, axi.awready, axi.bid, axi.bresp}, {1'b1, 1'b0, bprev});
      if (r_stall)
        chk("r_hold", {axi.rvalid, axi.arready, axi.rid, axi.rdata, axi.rresp, axi.rlast},
            {1'b1, 1'b0, rprev});
      if (axi.bvalid && axi.bready) begin
        if (b_q.size() == 0) fail_now("b_unexpected_empty_queue");
        else begin be = b_q.pop_front(); chk("b_resp", {axi.bid, axi.bresp}, be); end
      end
      if (axi.rvalid && axi.rready) begin
        if (r_q.size() == 0) fail_now("r_unexpected_empty_queue");
        else begin
          re = r_q.pop_front();
          chk("r_beat", {axi.rid, axi.rdata, axi.rresp, axi.rlast}, re);
        end
      end
      b_stall = axi.bvalid && !axi.bready;
      r_stall = axi.rvalid && !axi.rready;
      bprev   = '{id: axi.bid, resp: axi.bresp};
      rprev   = '{id: axi.rid, data: axi.rdata, resp: axi.rresp, last: axi.rlast};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0;
    axi.awburst = 0; axi.awprot = 0; axi.awqos = 0;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0;
    axi.arvalid = 0; axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0;
    axi.arburst = 0; axi.arprot = 0; axi.arqos = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, axi.rlast,
                        axi.bid, axi.rid, axi.bresp, axi.rresp, axi.rdata}, 64'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {axi.awready, axi.arready}, 2'b11);

    // Fill the whole RAM so every later read has a known expected value.
    for (int k = 0; k < DEPTH; k++) begin wd_a[k] = $urandom; ws_a[k] = 4'hF; end
    do_write(4'd0, 0, 255, 2, 1, 256); wait_idle();

    for (int k = 0; k < 4; k++) begin wd_a[k] = 32'h11111111 * (k + 1); ws_a[k] = 4'hF; end
    do_write(4'd3, 'h10, 3, 2, 1, 4); wait_idle();
    do_read(4'd3, 'h10, 3, 2, 1); wait_idle();

    wd_a[0] = 32'hAABBCCDD; ws_a[0] = 4'hF;
    do_write(4'd1, 'h40, 0, 2, 1, 1); wait_idle();
    wd_a[0] = 32'h0; ws_a[0] = 4'h5;
    do_write(4'd1, 'h40, 0, 2, 1, 1); wait_idle();
    chk("partial_strobe_model", mem_m['h40 / NB], 32'hAA00CC00);
    do_read(4'd2, 'h40, 0, 2, 1); wait_idle();

    do_read(4'd4, 'h38, 3, 2, 2); wait_idle();
    do_read(4'd5, 'h38, 2, 2, 2); wait_idle();

    wd_a[0] = 32'hDEADBEEF; ws_a[0] = 4'hF;
    do_write(4'd6, 'h400, 0, 2, 1, 1); wait_idle();
    for (int k = 0; k < 2; k++) begin wd_a[k] = $urandom; ws_a[k] = 4'hF; end
    do_write(4'd7, 'h80, 3, 2, 1, 2); wait_idle();
    do_read(4'd7, 'h80, 3, 2, 1); wait_idle();

    hold_b = 1'b1;
    for (int k = 0; k < 2; k++) begin wd_a[k] = $urandom; ws_a[k] = 4'hF; end
    do_write(4'd9, 'h100, 1, 2, 1, 2);
    repeat (5) @(negedge clk);
    hold_b = 1'b0; wait_idle();
    do_read(4'd8, 'h100, 7, 2, 1);
    repeat (2) @(negedge clk);
    hold_r = 1'b1;
    repeat (5) @(negedge clk);
    hold_r = 1'b0; wait_idle();

    for (int it = 0; it < 60; it++) begin
      int burst, size, len, addr, nb, r;
      logic [3:0] id;
      burst = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
      size  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      if (burst == 2)
        len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15))
                                           : (1 << $urandom_range(1, 4)) - 1;
      else
        len = int'($urandom_range(0, 9));
      addr = ($urandom_range(0, 7) == 0) ? int'($urandom_range('h3C0, 'h440))
                                          : int'($urandom_range(0, 'h3FF));
      id = 4'($urandom);
      if ($urandom_range(0, 9) < 6) begin
        nb = len + 1;
        r  = int'($urandom_range(0, 9));
        if (r == 0) nb = len + 2;
        else if (r == 1 && len > 0) nb = len;
        for (int k = 0; k < nb; k++) begin wd_a[k] = $urandom; ws_a[k] = 4'($urandom); end
        do_write(id, addr, len, size, burst, nb);
      end else begin
        do_read(id, addr, len, size, burst);
      end
      wait_idle();
    end

    // Reset in the middle of a write DATA phase: the burst is abandoned.
    begin
      int t;
      axi.awid = 4'd2; axi.awaddr = 32'h20; axi.awlen = 8'd3; axi.awsize = 3'd2;
      axi.awburst = 2'd1; axi.awvalid = 1'b1;
      t = 0;
      while (axi.awready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) fail_now("aw_handshake_rst");
      @(negedge clk);
      axi.awvalid = 1'b0;
      chk("wready_after_aw", axi.wready, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid,
                             axi.rlast}, 6'b0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("ready_after_release", {axi.awready, axi.arready, axi.wready}, 3'b110);
    end

    do_read(4'd9, 0, 255, 2, 1); wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
